// File: rtl/bram_program_loader_pkg.sv
// Shared definitions for the BRAM program loader: FSM states and stream framing constants.
package bram_program_loader_pkg;

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_CHECK,
    ST_DATA,
    ST_WRITE,
    ST_START,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HEADER_BYTES   = 4;
  localparam int unsigned BYTE_CNT_BITS  = 2;

endpackage

// File: rtl/bram_program_loader_byte_word_assembler.sv
// Collects four stream bytes little-endian into a 32-bit word; word_valid fires with the 4th byte.
module bram_program_loader_byte_word_assembler
  import bram_program_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out,
  output logic        pending
);

  localparam logic [BYTE_CNT_BITS-1:0] LAST_BYTE = BYTE_CNT_BITS'(BYTES_PER_WORD - 1);

  logic [BYTE_CNT_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]              word_q, word_d;

  always_comb begin
    cnt_d      = cnt_q;
    word_d     = word_q;
    word_valid = 1'b0;
    // Shifting in from the top leaves byte 0 in bits [7:0] after four bytes.
    word_out   = {byte_in, word_q[31:8]};
    if (clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_valid) begin
      word_d     = word_out;
      word_valid = (cnt_q == LAST_BYTE);
      cnt_d      = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign pending = (cnt_q != '0);

endmodule

// File: rtl/bram_program_loader.sv
// Loads a count-prefixed little-endian word stream into program BRAM, then releases and starts the core.
module bram_program_loader
  import bram_program_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDRESS_BITS     = 32,
  parameter int unsigned MEM_ADDRESS_BITS = 10,
  parameter logic [ADDRESS_BITS-1:0] BOOT_ADDRESS = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  output logic                        rx_ready,
  input  logic                        reload,
  output logic                        mem_write,
  output logic [MEM_ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]       mem_data,
  output logic                        core_reset,
  output logic                        start,
  output logic [ADDRESS_BITS-1:0]     program_address,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << MEM_ADDRESS_BITS;

  state_e                      state_q, state_d;
  logic [MEM_ADDRESS_BITS:0]   addr_q, addr_d;
  logic [31:0]                 count_q, count_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;

  logic        accept;
  logic        word_valid;
  logic [31:0] word_out;
  logic        pending;

  assign accept = rx_valid & rx_ready;

  bram_program_loader_byte_word_assembler u_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (reload),
    .byte_valid (accept),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word_out   (word_out),
    .pending    (pending)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    count_d         = count_q;
    data_d          = data_q;
    rx_ready        = 1'b0;
    mem_write       = 1'b0;
    start           = 1'b0;
    core_reset      = 1'b1;
    busy            = 1'b0;
    done            = 1'b0;
    error           = 1'b0;
    program_address = '0;

    unique case (state_q)
      ST_HEADER: begin
        rx_ready = 1'b1;
        busy     = pending;
        if (word_valid) begin
          count_d = word_out;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (count_q == '0 || count_q > MAX_WORDS) begin
          state_d = ST_ERROR;
        end else begin
          addr_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (word_valid) begin
          data_d  = word_out;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        addr_d    = addr_q + 1'b1;
        // Counter is one bit wider than the BRAM address so a full image compares without wrap.
        state_d   = (32'(addr_q) + 32'd1 == count_q) ? ST_START : ST_DATA;
      end
      ST_START: begin
        busy            = 1'b1;
        core_reset      = 1'b0;
        start           = 1'b1;
        program_address = BOOT_ADDRESS;
        state_d         = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        core_reset = 1'b0;
      end
      ST_ERROR: begin
        error = 1'b1;
      end
      default: state_d = ST_HEADER;
    endcase

    if (reload) begin
      state_d = ST_HEADER;
      addr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HEADER;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign mem_address = addr_q[MEM_ADDRESS_BITS-1:0];
  assign mem_data    = data_q;

endmodule

// File: tb/tb_bram_program_loader.sv
// Scoreboard bench for bram_program_loader: a stream model queues expected writes/start, a monitor checks them.
module tb_bram_program_loader;

  localparam int unsigned MAB = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic        mem_write;
  logic [MAB-1:0] mem_address;
  logic [31:0] mem_data;
  logic        core_reset;
  logic        start;
  logic [31:0] program_address;
  logic        busy, done, error;

  bram_program_loader #(
    .DATA_WIDTH(32), .ADDRESS_BITS(32), .MEM_ADDRESS_BITS(MAB), .BOOT_ADDRESS(32'h0)
  ) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .core_reset(core_reset), .start(start), .program_address(program_address),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_start;
    int unsigned addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  exp_t sb[$];
  wr_t  wr_log[$];
  int unsigned total = 0;
  int unsigned passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write or start pulse must match the head of the scoreboard.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset && (mem_write || start)) begin
      if (mem_write) wr_log.push_back('{addr: 32'(mem_address), data: mem_data});
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_event: got write=%0b start=%0b addr=%0h expected none", mem_write, start, mem_address);
      end else begin
        e = sb.pop_front();
        check("event_kind_is_start", 64'(start), 64'(e.is_start));
        if (e.is_start) begin
          check("program_address", 64'(program_address), 64'h0);
          check("core_reset_at_start", 64'(core_reset), 64'h0);
          check("no_write_with_start", 64'(mem_write), 64'h0);
        end else begin
          check("write_addr", 64'(mem_address), 64'(e.addr));
          check("write_data", 64'(mem_data), 64'(e.data));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
    bit ok;
    ok = 1'b0;
    if (max_gap > 0) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat ($urandom_range(max_gap, 1)) @(posedge clock);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      ok = rx_ready;
      @(posedge clock);
      #1;
      if (ok) break;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL handshake_timeout: got rx_ready=0 expected 1 for byte %0h", b);
    end
  endtask

  // Reference model: header gives N; if 1..2**MAB, word i lands at address i, then one start.
  task automatic send_image(input logic [31:0] n, input logic [31:0] words[$],
                            input int unsigned max_gap, input int unsigned byte_limit);
    int unsigned sent;
    bit valid_n;
    sent = 0;
    for (int unsigned k = 0; k < 4; k++) send_byte(n[8*k +: 8], max_gap);
    valid_n = (n != 0) && (n <= (32'd1 << MAB));
    if (!valid_n) return;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (sent == byte_limit) return;
        send_byte(words[i][8*k +: 8], max_gap);
        sent++;
      end
      sb.push_back('{is_start: 1'b0, addr: i, data: words[i]});
    end
    sb.push_back('{is_start: 1'b1, addr: 0, data: '0});
  endtask

  task automatic rand_words(input int unsigned n, output logic [31:0] w[$]);
    w = {};
    for (int unsigned i = 0; i < n; i++) w.push_back(32'($urandom));
  endtask

  task automatic wait_end(input bit want_done, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done || error) break;
    end
    check({tag, "_done"}, 64'(done), 64'(want_done));
    check({tag, "_error"}, 64'(error), 64'(!want_done));
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'h0);
    check({tag, "_core_reset"}, 64'(core_reset), 64'(!want_done));
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'h0);
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reload(input string tag);
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
    check({tag, "_reload_done"}, 64'(done), 64'h0);
    check({tag, "_reload_error"}, 64'(error), 64'h0);
    check({tag, "_reload_core_reset"}, 64'(core_reset), 64'h1);
    check({tag, "_reload_rx_ready"}, 64'(rx_ready), 64'h1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'h1);
    check({tag, "_core_reset"}, 64'(core_reset), 64'h1);
    check({tag, "_mem_write"}, 64'(mem_write), 64'h0);
    check({tag, "_start"}, 64'(start), 64'h0);
    check({tag, "_mem_address"}, 64'(mem_address), 64'h0);
    check({tag, "_mem_data"}, 64'(mem_data), 64'h0);
    check({tag, "_program_address"}, 64'(program_address), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_done"}, 64'(done), 64'h0);
    check({tag, "_error"}, 64'(error), 64'h0);
  endtask

  initial begin : stimulus
    logic [31:0] w[$];
    wr_t run_a[$];
    logic [31:0] n;

    #12;
    check_reset_values("reset");
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Known image; busy rises after the first header byte.
    w = '{32'h00000013, 32'h00a00093, 32'h00000513};
    send_byte(8'h03, 0);
    check("busy_after_first_byte", 64'(busy), 64'h1);
    for (int unsigned k = 1; k < 4; k++) send_byte(8'h00, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned k = 0; k < 4; k++) send_byte(w[i][8*k +: 8], 0);
      sb.push_back('{is_start: 1'b0, addr: i, data: w[i]});
    end
    sb.push_back('{is_start: 1'b1, addr: 0, data: '0});
    wait_end(1'b1, "n3");

    pulse_reload("after_done");
    rand_words(2, w);
    send_image(32'd2, w, 0, 32'hFFFF_FFFF);
    wait_end(1'b1, "n2");

    pulse_reload("pre_zero");
    send_image(32'd0, w, 0, 32'hFFFF_FFFF);
    wait_end(1'b0, "n0");

    pulse_reload("pre_1025");
    send_image(32'd1025, w, 0, 32'hFFFF_FFFF);
    wait_end(1'b0, "n1025");

    pulse_reload("pre_1024");
    rand_words(1024, w);
    wr_log = {};
    send_image(32'd1024, w, 0, 32'hFFFF_FFFF);
    wait_end(1'b1, "n1024");
    check("n1024_write_count", 64'(wr_log.size()), 64'd1024);
    if (wr_log.size() > 0) check("n1024_last_addr", 64'(wr_log[wr_log.size()-1].addr), 64'h3FF);

    // Same N=4 image with and without rx_valid gaps must write identically.
    pulse_reload("pre_gapfree");
    rand_words(4, w);
    wr_log = {};
    send_image(32'd4, w, 0, 32'hFFFF_FFFF);
    wait_end(1'b1, "gapfree");
    run_a = wr_log;
    pulse_reload("pre_gapped");
    wr_log = {};
    send_image(32'd4, w, 7, 32'hFFFF_FFFF);
    wait_end(1'b1, "gapped");
    check("gapped_write_count", 64'(wr_log.size()), 64'(run_a.size()));
    for (int unsigned i = 0; i < 4 && i < wr_log.size() && i < run_a.size(); i++) begin
      check("gapped_addr_match", 64'(wr_log[i].addr), 64'(run_a[i].addr));
      check("gapped_data_match", 64'(wr_log[i].data), 64'(run_a[i].data));
    end

    // Async reset in the middle of word 2 of an N=5 image.
    pulse_reload("pre_midreset");
    rand_words(5, w);
    send_image(32'd5, w, 0, 6);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    check("midreset_sb_drained", 64'(sb.size()), 64'h0);
    sb = {};
    @(posedge clock);
    #1;
    reset = 1'b1;
    rand_words(3, w);
    send_image(32'd3, w, 0, 32'hFFFF_FFFF);
    wait_end(1'b1, "after_reset");

    // Random images, sizes and gaps.
    for (int r = 0; r < 6; r++) begin
      pulse_reload("rand");
      n = 32'($urandom_range(8, 1));
      rand_words(n, w);
      send_image(n, w, $urandom_range(3, 0), 32'hFFFF_FFFF);
      wait_end(1'b1, "rand");
    end

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
